// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, state and flag types for the ALU family
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6,
        ALU_SRA = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic ovf;
    } alu_flags_t;

    function automatic logic is_shift(input alu_op_e op);
        return (op == ALU_SHL) || (op == ALU_SHR) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational add/sub/logic unit with carry and signed overflow
//   op_i      opcode (only ADD..XOR meaningful; shift opcodes yield zero)
//   a_i, b_i  operands
//   result_o  WIDTH-bit result
//   carry_o   carry out (ADD) or borrow (SUB), 0 for logic ops
//   ovf_o     signed overflow for ADD/SUB, 0 otherwise
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  alu_op_e          op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             ovf_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // The extra top bit of the WIDTH+1 result is the carry, or the borrow for SUB.
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        ovf_o    = 1'b0;
        case (op_i)
            ALU_ADD: begin
                result_o = sum[WIDTH-1:0];
                carry_o  = sum[WIDTH];
                ovf_o    = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_SUB: begin
                result_o = diff[WIDTH-1:0];
                carry_o  = diff[WIDTH];
                ovf_o    = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - handshaked multicycle ALU with iterative one-bit-per-cycle shifts
//   clk_i, rst_i              clock, synchronous active-high reset
//   in_valid_i / in_ready_o   operation handshake (cntrl_alu_i, reg_a_i, reg_b_i)
//   out_valid_o / out_ready_i result handshake (result_o and flags)
//   carry_o, zero_o, neg_o, ovf_o  registered flags
//   busy_o                    an operation is in flight
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       cntrl_alu_i,
    input  logic [WIDTH-1:0] reg_a_i,
    input  logic [WIDTH-1:0] reg_b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             zero_o,
    output logic             neg_o,
    output logic             ovf_o,
    output logic             busy_o
);

    localparam int SHAMT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    alu_op_e            op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    alu_flags_t         flags_q, flags_d;
    logic               in_ready_q, in_ready_d;

    logic [WIDTH-1:0]   core_result;
    logic               core_carry;
    logic               core_ovf;
    logic [WIDTH-1:0]   shift_next;
    logic               shift_out;
    logic [SHAMT_W-1:0] shamt_in;
    alu_op_e            op_in;

    assign shamt_in = reg_b_i[SHAMT_W-1:0];
    assign op_in    = alu_op_e'(cntrl_alu_i);

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (core_result),
        .carry_o  (core_carry),
        .ovf_o    (core_ovf)
    );

    // One-bit shift step of the working register and the bit that falls off.
    always_comb begin
        shift_next = a_q;
        shift_out  = 1'b0;
        case (op_q)
            ALU_SHL: begin
                shift_next = {a_q[WIDTH-2:0], 1'b0};
                shift_out  = a_q[WIDTH-1];
            end
            ALU_SHR: begin
                shift_next = {1'b0, a_q[WIDTH-1:1]};
                shift_out  = a_q[0];
            end
            ALU_SRA: begin
                shift_next = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
                shift_out  = a_q[0];
            end
            default: begin
                shift_next = a_q;
                shift_out  = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i && in_ready_q) begin
                    op_d = op_in;
                    a_d  = reg_a_i;
                    b_d  = reg_b_i;
                    if (!is_shift(op_in)) begin
                        state_d = ST_EXEC;
                    end else if (shamt_in != '0) begin
                        cnt_d   = shamt_in;
                        state_d = ST_SHIFT;
                    end else begin
                        // Zero-distance shift: pass A through with nothing shifted out.
                        result_d = reg_a_i;
                        flags_d  = '{carry: 1'b0, zero: (reg_a_i == '0),
                                     neg: reg_a_i[WIDTH-1], ovf: 1'b0};
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_EXEC: begin
                result_d = core_result;
                flags_d  = '{carry: core_carry, zero: (core_result == '0),
                             neg: core_result[WIDTH-1], ovf: core_ovf};
                state_d  = ST_DONE;
            end
            ST_SHIFT: begin
                a_d           = shift_next;
                flags_d.carry = shift_out;
                cnt_d         = cnt_q - 1'b1;
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d = shift_next;
                    flags_d  = '{carry: shift_out, zero: (shift_next == '0),
                                 neg: shift_next[WIDTH-1], ovf: 1'b0};
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered so that ready stays low through every reset cycle.
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            op_q       <= ALU_ADD;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            flags_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q == ST_DONE);
    assign busy_o      = (state_q != ST_IDLE);
    assign result_o    = result_q;
    assign carry_o     = flags_q.carry;
    assign zero_o      = flags_q.zero;
    assign neg_o       = flags_q.neg;
    assign ovf_o       = flags_q.ovf;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - scoreboard bench for alu_multicycle with directed vectors
module tb_alu_multicycle;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [2:0]   cntrl_alu_i = 3'd0;
    logic [W-1:0] reg_a_i = '0;
    logic [W-1:0] reg_b_i = '0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b1;
    logic [W-1:0] result_o;
    logic         carry_o, zero_o, neg_o, ovf_o, busy_o;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .cntrl_alu_i (cntrl_alu_i),
        .reg_a_i     (reg_a_i),
        .reg_b_i     (reg_b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .carry_o     (carry_o),
        .zero_o      (zero_o),
        .neg_o       (neg_o),
        .ovf_o       (ovf_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         c, z, n, v;
        int           lat;
        int           acc;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   compared   = 0;
    int   mismatched = 0;
    bit   seen       = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compare the head of the scoreboard on the first valid cycle, pop on handshake.
    always @(negedge clk) begin
        if (rst_i) begin
            seen = 0;
        end else if (out_valid_o) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_valid: got result %0h with empty scoreboard", result_o);
            end else begin
                if (!seen) begin
                    seen = 1;
                    cur  = sb[0];
                    check({cur.name, ".result"},  32'(result_o), 32'(cur.res));
                    check({cur.name, ".carry"},   32'(carry_o),  32'(cur.c));
                    check({cur.name, ".zero"},    32'(zero_o),   32'(cur.z));
                    check({cur.name, ".neg"},     32'(neg_o),    32'(cur.n));
                    check({cur.name, ".ovf"},     32'(ovf_o),    32'(cur.v));
                    check({cur.name, ".latency"}, 32'(cyc - cur.acc + 1), 32'(cur.lat));
                end
                if (out_ready_i) begin
                    void'(sb.pop_front());
                    seen = 0;
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] r, input logic c, input logic z,
                         input logic n, input logic v, input int lat, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid_i  = 1'b1;
        cntrl_alu_i = op;
        reg_a_i     = a;
        reg_b_i     = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready_o) break;
        end
        if (!in_ready_o) begin
            compared++;
            mismatched++;
            $display("FAIL %s.accept_timeout: in_ready_o got 0 expected 1", nm);
        end else begin
            e.res = r; e.c = c; e.z = z; e.n = n; e.v = v;
            e.lat = lat; e.acc = cyc + 1; e.name = nm;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s.done_timeout: pending got %0d expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_idle_outputs(input string nm, input logic exp_ready);
        check({nm, ".out_valid"}, 32'(out_valid_o), 32'd0);
        check({nm, ".result"},    32'(result_o),    32'd0);
        check({nm, ".carry"},     32'(carry_o),     32'd0);
        check({nm, ".zero"},      32'(zero_o),      32'd0);
        check({nm, ".neg"},       32'(neg_o),       32'd0);
        check({nm, ".ovf"},       32'(ovf_o),       32'd0);
        check({nm, ".busy"},      32'(busy_o),      32'd0);
        check({nm, ".in_ready"},  32'(in_ready_o),  32'(exp_ready));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset", 1'b0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_release.in_ready", 32'(in_ready_o), 32'd1);

        // Directed vectors: op, A, B, result, carry, zero, neg, ovf, latency
        issue(ALU_ADD, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0, 2, "add_ff_01");   wait_done("add_ff_01");
        issue(ALU_SUB, 8'h80, 8'h01, 8'h7F, 0, 0, 0, 1, 2, "sub_80_01");   wait_done("sub_80_01");
        issue(ALU_SUB, 8'h01, 8'h02, 8'hFF, 1, 0, 1, 0, 2, "sub_01_02");   wait_done("sub_01_02");
        issue(ALU_SRA, 8'h90, 8'h03, 8'hF2, 0, 0, 1, 0, 4, "sra_90_3");    wait_done("sra_90_3");
        issue(ALU_SHL, 8'h81, 8'h01, 8'h02, 1, 0, 0, 0, 2, "shl_81_1");    wait_done("shl_81_1");
        issue(ALU_SHR, 8'h5A, 8'h08, 8'h5A, 0, 0, 0, 0, 1, "shr_5a_0");    wait_done("shr_5a_0");
        issue(ALU_XOR, 8'hAA, 8'hAA, 8'h00, 0, 1, 0, 0, 2, "xor_aa_aa");   wait_done("xor_aa_aa");
        issue(ALU_OR,  8'h0F, 8'h30, 8'h3F, 0, 0, 0, 0, 2, "or_0f_30");    wait_done("or_0f_30");
        issue(ALU_ADD, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1, 2, "add_7f_01");   wait_done("add_7f_01");
        issue(ALU_SHR, 8'h81, 8'h01, 8'h40, 1, 0, 0, 0, 2, "shr_81_1");    wait_done("shr_81_1");
        issue(ALU_SRA, 8'h80, 8'h07, 8'hFF, 0, 0, 1, 0, 8, "sra_80_7");    wait_done("sra_80_7");

        // Backpressure: hold out_ready_i low while an extra op is offered
        out_ready_i = 1'b0;
        issue(ALU_AND, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 2, "and_bp");
        for (int i = 0; i < 20; i++) begin
            if (out_valid_o) break;
            @(negedge clk);
        end
        check("bp.reached_done", 32'(out_valid_o), 32'd1);
        @(posedge clk);
        #1;
        in_valid_i  = 1'b1;
        cntrl_alu_i = ALU_ADD;
        reg_a_i     = 8'h11;
        reg_b_i     = 8'h22;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp.result",    32'(result_o),    32'h30);
            check("bp.carry",     32'(carry_o),     32'd0);
            check("bp.zero",      32'(zero_o),      32'd0);
            check("bp.out_valid", 32'(out_valid_o), 32'd1);
            check("bp.in_ready",  32'(in_ready_o),  32'd0);
        end
        @(posedge clk);
        #1;
        out_ready_i = 1'b1;
        in_valid_i  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("bp.complete_valid", 32'(out_valid_o), 32'd0);
        check("bp.complete_busy",  32'(busy_o),      32'd0);
        check("bp.complete_ready", 32'(in_ready_o),  32'd1);
        check("bp.scoreboard",     32'(sb.size()),   32'd0);

        // Reset during the third SHIFT cycle of SHL by 7
        @(posedge clk);
        #1;
        in_valid_i  = 1'b1;
        cntrl_alu_i = ALU_SHL;
        reg_a_i     = 8'h01;
        reg_b_i     = 8'h07;
        @(negedge clk);
        check("rst_mid.accept_ready", 32'(in_ready_o), 32'd1);
        @(posedge clk);
        #1 in_valid_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_mid.busy_before", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("rst_mid", 1'b0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid.ready_after", 32'(in_ready_o), 32'd1);
        check("rst_mid.valid_after", 32'(out_valid_o), 32'd0);
        issue(ALU_ADD, 8'h12, 8'h34, 8'h46, 0, 0, 0, 0, 2, "add_after_rst");
        wait_done("add_after_rst");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
